led_pwm_ctrl: RTL and testbench

Per-channel PWM brightness controller for the 12 board LEDs (4 × RGB). It sits between the SoC/top level and the LED pins. A valid/ready configuration port writes 4-bit duty values into shadow registers, and those values are copied to the active registers only at PWM period boundaries, so LED output never glitches. A shared prescaler and period counter generate all channels in phase.

---
 rtl/led_pwm_ctrl.sv | 125 ++++++++++++
 tb/tb_led_pwm_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/led_pwm_ctrl.sv
// Twelve-channel LED PWM controller: shadow duty registers written over a valid/ready port,
// copied to the active set only at period boundaries so outputs never glitch mid-period.
module led_pwm_ctrl #(
    parameter int NUM_CH   = 12,
    parameter int DUTY_W   = 4,
    parameter int PRESCALE = 1024
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [3:0]        cfg_addr,
    input  logic [DUTY_W-1:0] cfg_duty,
    output logic              cfg_err,
    output logic              period_start,
    output logic [NUM_CH-1:0] led
);

    localparam int PRE_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(PRESCALE - 1);
    localparam logic [DUTY_W-1:0] CNT_MAX  = DUTY_W'((1 << DUTY_W) - 2);
    localparam logic [4:0]        NUM_CH_L = 5'(NUM_CH);

    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [DUTY_W-1:0] cnt_q, cnt_d;
    logic              restart_q, restart_d;
    logic              err_q, err_d;
    logic [NUM_CH-1:0] led_q, led_d;
    logic [DUTY_W-1:0] shadow_q [NUM_CH];
    logic [DUTY_W-1:0] shadow_d [NUM_CH];
    logic [DUTY_W-1:0] active_q [NUM_CH];

    logic tick;
    logic wrap;
    logic load;
    logic accept;
    logic addrOk;

    // Load is gated by resetn so the outputs show their idle values while reset is held.
    assign tick   = en && (pre_q == PRE_MAX);
    assign wrap   = tick && (cnt_q == CNT_MAX);
    assign load   = resetn && en && (wrap || restart_q);
    assign addrOk = ({1'b0, cfg_addr} < NUM_CH_L);
    assign accept = cfg_valid && cfg_ready;

    assign cfg_ready    = !load;
    assign period_start = load;
    assign cfg_err      = err_q;
    assign led          = led_q;

    always_comb begin
        pre_d = pre_q;
        cnt_d = cnt_q;
        if (!en) begin
            pre_d = '0;
            cnt_d = '0;
        end else if (tick) begin
            pre_d = '0;
            cnt_d = wrap ? '0 : cnt_q + DUTY_W'(1);
        end else begin
            pre_d = pre_q + PRE_W'(1);
        end
    end

    always_comb begin
        restart_d = restart_q;
        if (!en) begin
            restart_d = 1'b1;
        end else if (load) begin
            restart_d = 1'b0;
        end
    end

    always_comb begin
        err_d = accept && !addrOk;
        for (int i = 0; i < NUM_CH; i++) begin
            shadow_d[i] = shadow_q[i];
            if (accept && addrOk && (cfg_addr == 4'(i))) begin
                shadow_d[i] = cfg_duty;
            end
        end
    end

    // Compare uses the registered active set and count, so led lags them by one cycle.
    always_comb begin
        led_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            led_d[i] = en && (active_q[i] > cnt_q);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pre_q     <= '0;
            cnt_q     <= '0;
            restart_q <= 1'b1;
            err_q     <= 1'b0;
            led_q     <= '0;
        end else begin
            pre_q     <= pre_d;
            cnt_q     <= cnt_d;
            restart_q <= restart_d;
            err_q     <= err_d;
            led_q     <= led_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= shadow_d[i];
                if (load) begin
                    active_q[i] <= shadow_q[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Directed bench for led_pwm_ctrl with PRESCALE = 4, giving a 60-cycle PWM period;
// per-channel high-cycle counts over a window are compared with hand-derived duty times four.
module tb_led_pwm_ctrl;

    localparam int NUM_CH   = 12;
    localparam int DUTY_W   = 4;
    localparam int PRESCALE = 4;

    logic              clk = 1'b0;
    logic              resetn;
    logic              en;
    logic              cfgValid;
    logic              cfgReady;
    logic [3:0]        cfgAddr;
    logic [DUTY_W-1:0] cfgDuty;
    logic              cfgErr;
    logic              periodStart;
    logic [NUM_CH-1:0] led;

    int checks = 0;
    int errors = 0;
    int highCnt [NUM_CH];
    int psCnt;
    int readyLow;
    int errCnt;
    int n;

    led_pwm_ctrl #(
        .NUM_CH   (NUM_CH),
        .DUTY_W   (DUTY_W),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .en           (en),
        .cfg_valid    (cfgValid),
        .cfg_ready    (cfgReady),
        .cfg_addr     (cfgAddr),
        .cfg_duty     (cfgDuty),
        .cfg_err      (cfgErr),
        .period_start (periodStart),
        .led          (led)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] a, input logic [DUTY_W-1:0] d);
        cfgValid = v;
        cfgAddr  = a;
        cfgDuty  = d;
    endtask

    task automatic clearCounts();
        for (int i = 0; i < NUM_CH; i++) highCnt[i] = 0;
        psCnt    = 0;
        readyLow = 0;
        errCnt   = 0;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_CH; i++) if (led[i]) highCnt[i]++;
        if (periodStart) psCnt++;
        if (!cfgReady) readyLow++;
        if (cfgErr) errCnt++;
    endtask

    task automatic waitLoad(input string tag, output int cyc);
        cyc = 0;
        do begin
            stepCycle();
            cyc++;
        end while (!periodStart && cyc < 100);
        checkOutput(tag, int'(periodStart), 1);
    endtask

    task automatic writeCfg(input logic [3:0] a, input logic [DUTY_W-1:0] d);
        applyStimulus(1'b1, a, d);
        stepCycle();
        applyStimulus(1'b0, 4'd0, '0);
    endtask

    function automatic int highSumExcept(input int a, input int b, input int c);
        int s = 0;
        for (int i = 0; i < NUM_CH; i++) if (i != a && i != b && i != c) s += highCnt[i];
        return s;
    endfunction

    initial begin
        resetn = 1'b0;
        en     = 1'b1;
        applyStimulus(1'b0, 4'd0, '0);
        clearCounts();
        repeat (3) stepCycle();
        checkOutput("rstLed",   int'(led),         0);
        checkOutput("rstReady", int'(cfgReady),    1);
        checkOutput("rstPs",    int'(periodStart), 0);
        checkOutput("rstErr",   int'(cfgErr),      0);

        // First enabled cycle after release is a restart load.
        resetn = 1'b1;
        #1;
        checkOutput("firstLoadPs",    int'(periodStart), 1);
        checkOutput("firstLoadReady", int'(cfgReady),    0);

        waitLoad("firstWrap", n);
        clearCounts();
        waitLoad("secondWrap", n);
        checkOutput("periodLen",  n, 60);
        checkOutput("readyLowCnt", readyLow, 1);
        checkOutput("psCnt",       psCnt, 1);
        checkOutput("idleLed",     highSumExcept(-1, -1, -1), 0);

        stepCycle();
        checkOutput("readyAfterLoad", int'(cfgReady), 1);
        writeCfg(4'd0, 4'd5);
        writeCfg(4'd11, 4'd15);
        waitLoad("loadA", n);
        waitLoad("loadB", n);
        clearCounts();
        waitLoad("loadC", n);
        checkOutput("ch0Duty5",   highCnt[0], 20);
        checkOutput("ch11Duty15", highCnt[11], 60);
        checkOutput("othersOff",  highSumExcept(0, 11, -1), 0);

        // Write held across a load cycle is stalled, then lands in the following cycle.
        applyStimulus(1'b1, 4'd3, 4'd7);
        #1;
        checkOutput("stallReady", int'(cfgReady), 0);
        stepCycle();
        checkOutput("retryReady", int'(cfgReady), 1);
        stepCycle();
        applyStimulus(1'b0, 4'd0, '0);
        clearCounts();
        waitLoad("loadD", n);
        checkOutput("ch3Held", highCnt[3], 0);
        clearCounts();
        waitLoad("loadE", n);
        checkOutput("ch3Duty7",   highCnt[3], 28);
        checkOutput("ch0Steady",  highCnt[0], 20);

        stepCycle();
        applyStimulus(1'b1, 4'd12, 4'd9);
        stepCycle();
        applyStimulus(1'b0, 4'd0, '0);
        checkOutput("errPulse", int'(cfgErr), 1);
        stepCycle();
        checkOutput("errOneCycle", int'(cfgErr), 0);
        waitLoad("loadF", n);
        clearCounts();
        waitLoad("loadG", n);
        checkOutput("badAddrCh0",  highCnt[0], 20);
        checkOutput("badAddrCh3",  highCnt[3], 28);
        checkOutput("badAddrCh11", highCnt[11], 60);
        checkOutput("badAddrOthers", highSumExcept(0, 3, 11), 0);
        checkOutput("noStrayErr",  errCnt, 0);

        repeat (10) stepCycle();
        en = 1'b0;
        #1;
        checkOutput("disReady", int'(cfgReady),    1);
        checkOutput("disPs",    int'(periodStart), 0);
        stepCycle();
        checkOutput("disLed", int'(led),       0);
        checkOutput("disPre", int'(dut.pre_q), 0);
        checkOutput("disCnt", int'(dut.cnt_q), 0);
        repeat (3) stepCycle();
        en = 1'b1;
        #1;
        checkOutput("restartPs", int'(periodStart), 1);
        clearCounts();
        stepCycle();
        checkOutput("restartLed0", int'(led[0]), 1);
        repeat (39) stepCycle();
        checkOutput("restartCh0",  highCnt[0], 20);
        checkOutput("restartCh3",  highCnt[3], 28);
        checkOutput("restartCh11", highCnt[11], 40);

        writeCfg(4'd0, 4'd15);
        waitLoad("preResetLoad", n);
        repeat (5) stepCycle();
        checkOutput("ch0FullOn", int'(led[0]), 1);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("asyncRstLed",   int'(led),         0);
        checkOutput("asyncRstReady", int'(cfgReady),    1);
        checkOutput("asyncRstPs",    int'(periodStart), 0);
        stepCycle();
        resetn = 1'b1;
        #1;
        checkOutput("postRstLoad", int'(periodStart), 1);
        clearCounts();
        repeat (60) stepCycle();
        checkOutput("postRstLed", highSumExcept(-1, -1, -1), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
